// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared sizing constants and register-index type for the register file
package reg_file_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/mux32_to_1.sv
// mux32_to_1: 32-way word selector used for each register-file read port
module mux32_to_1
  import reg_file_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [31:0][W-1:0] i_in,
  input  reg_idx_t           i_sel,
  output logic [W-1:0]       o_out
);
  assign o_out = i_in[i_sel];
endmodule

// File: rtl/reg_file_core.sv
// reg_file_core: 32-entry register file with write-through reads and a pending-producer scoreboard
module reg_file_core
  import reg_file_pkg::*;
#(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              pend_a,
  output logic              pend_b,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int NR = 2 ** ADDR_W;
  logic [NR-1:0][DATA_W-1:0] r_regs;
  logic [NR-1:0]             r_pend;
  logic [ADDR_W:0]           r_busy;
  logic [NR-1:0]             w_pend_nx;
  logic [ADDR_W:0]           w_busy_nx;
  logic [DATA_W-1:0]         w_mux_a;
  logic [DATA_W-1:0]         w_mux_b;
  // set is applied after clear so a same-cycle reservation beats the write-back
  always_comb begin
    w_pend_nx = r_pend;
    if (wr_en) w_pend_nx[wr_addr] = 1'b0;
    if (rsv_en) w_pend_nx[rsv_addr] = 1'b1;
    w_pend_nx[0] = 1'b0;
    w_busy_nx = '0;
    for (int i = 1; i < NR; i++) w_busy_nx = w_busy_nx + (ADDR_W + 1)'(w_pend_nx[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '0;
      r_pend <= '0;
      r_busy <= '0;
    end else begin
      if (wr_en && wr_addr != '0) r_regs[wr_addr] <= wr_data;
      r_pend <= w_pend_nx;
      r_busy <= w_busy_nx;
    end
  end
  mux32_to_1 #(.W(DATA_W)) u_mux_a (.i_in(r_regs), .i_sel(rd_addr_a), .o_out(w_mux_a));
  mux32_to_1 #(.W(DATA_W)) u_mux_b (.i_in(r_regs), .i_sel(rd_addr_b), .o_out(w_mux_b));
  assign rd_data_a = (rd_addr_a == '0) ? '0 : (wr_en && wr_addr == rd_addr_a) ? wr_data : w_mux_a;
  assign rd_data_b = (rd_addr_b == '0) ? '0 : (wr_en && wr_addr == rd_addr_b) ? wr_data : w_mux_b;
  assign pend_a = (rd_addr_a != '0) && r_pend[rd_addr_a];
  assign pend_b = (rd_addr_b != '0) && r_pend[rd_addr_b];
  assign busy_cnt = r_busy;
endmodule

// File: doc/reg_file_core.md
REG_FILE_CORE -- requirements
Module: reg_file_core

Interface
REQ-001: Parameter DATA_W, default 32, register and data-port width.
REQ-002: Parameter ADDR_W, default 5, register address width (NREGS = 2**ADDR_W = 32).
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: wr_en  input  1  write-back strobe, one register per asserted cycle.
REQ-006: wr_addr  input  ADDR_W  write-back destination index.
REQ-007: wr_data  input  DATA_W  write-back value.
REQ-008: rsv_en  input  1  issue strobe, marks rsv_addr as pending (producer in flight).
REQ-009: rsv_addr  input  ADDR_W  register being reserved.
REQ-010: rd_addr_a, rd_addr_b  input  ADDR_W each  read-port indices.
REQ-011: rd_data_a, rd_data_b  output  DATA_W each  read-port data, combinational from addresses.
REQ-012: pend_a, pend_b  output  1 each  rd_addr_a/rd_addr_b currently reserved and not yet written back.
REQ-013: busy_cnt  output  ADDR_W+1  number of registers currently pending, 0..31.

Function
REQ-014: Storage SHALL be NREGS x DATA_W flops; register 0 SHALL read as 0 always and ignore writes and reservations.
REQ-015: wr_en=1 with wr_addr!=0 SHALL update reg[wr_addr] at the rising edge; write latency 1 cycle.
REQ-016: Reads SHALL be write-through: if wr_en=1 and wr_addr==rd_addr_x!=0 in the same cycle, rd_data_x SHALL equal wr_data (bypass), else the stored value.
REQ-017: Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-018: Pending bit p[i] SHALL set at the edge when rsv_en=1 and rsv_addr==i!=0.
REQ-019: Pending bit p[i] SHALL clear at the edge when wr_en=1 and wr_addr==i.
REQ-020: Simultaneous reserve and write-back to the same index SHALL leave p[i]=1 (new producer wins); data still written.
REQ-021: Reserve of an already-pending index SHALL keep p[i]=1 and not change busy_cnt.
REQ-022: Write-back to a non-pending index SHALL write data and leave p[i]=0 (no error, no underflow).
REQ-023: pend_x SHALL reflect registered p[rd_addr_x] with no bypass of same-cycle set or clear; pend_x for address 0 SHALL be 0.
REQ-024: busy_cnt SHALL equal the population count of p[31:1] after each edge, registered, never wrapping.

Reset
REQ-025: rst=1 at an edge SHALL clear all 32 registers to 0, all pending bits to 0, busy_cnt to 0.
REQ-026: rst SHALL override wr_en and rsv_en in the same cycle; no write or reservation takes effect.
REQ-027: During rst=1 read outputs SHALL still follow REQ-016 combinationally; values settle to 0 after the reset edge.

Structure
REQ-028: Package reg_file_pkg SHALL hold DATA_W, ADDR_W, NREGS constants and the register-index type.
REQ-029: Read-port selection SHALL instantiate the existing mux32_to_1 once per port; write decode and scoreboard stay in reg_file_core.
REQ-030: No other sub-module; bypass compare and popcount inline.

Verification
REQ-031: Reset, then wr_en=1 wr_addr=5 wr_data=0xDEADBEEF, rd_addr_a=5 same cycle -> rd_data_a=0xDEADBEEF that cycle and after.
REQ-032: wr_en=1 wr_addr=0 wr_data=0xFFFFFFFF, rsv_en=1 rsv_addr=0 -> rd_data_a(addr 0)=0, pend_a=0, busy_cnt=0.
REQ-033: rsv_en on 3 then 7 on consecutive cycles -> pend for 3,7 =1, busy_cnt=2; write-back 3 -> busy_cnt=1, pend(3)=0.
REQ-034: Same cycle rsv_addr=9 and wr_addr=9 (data 0x1234) with p[9]=1 -> p[9]=1, reg9=0x1234, busy_cnt unchanged.
REQ-035: Reserve all 31 registers -> busy_cnt=31; assert rst mid-stream with wr_en=1 -> all regs 0, busy_cnt=0 next cycle.
REQ-036: Random 10k-cycle reads/writes/reserves vs. reference array model -> zero data or pending mismatches.
